// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding and counter sizing helpers
package uart_pkg;

    typedef logic [1:0] uart_state_t;

    localparam uart_state_t IDLE  = 2'd0;
    localparam uart_state_t START = 2'd1;
    localparam uart_state_t DATA  = 2'd2;
    localparam uart_state_t STOP  = 2'd3;

    localparam int OVERSAMPLE = 16;

    // Width of a counter that must hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/baud_rate_gen.sv
// rtl/baud_rate_gen.sv - oversample tick divider shared by the UART transmitter and receiver
module baud_rate_gen
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = 326
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    output logic o_tick
);

    localparam int                DIV_W    = cnt_width(BAUD_DIV);
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(BAUD_DIV - 1);

    logic [DIV_W-1:0] div_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            div_cnt <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign o_tick = (div_cnt == DIV_LAST);

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 UART transmitter with 16x oversampled bit timing
module uart_tx
    import uart_pkg::*;
#(
    parameter int N_DATA_BITS  = 8,
    parameter int N_STOP_TICKS = 16,
    parameter int BAUD_DIV     = 326
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_DATA_BITS-1:0] i_tx_data,
    input  logic                   is_tx_start,
    output logic                   o_tx,
    output logic                   os_tx_done,
    output logic                   o_tx_busy
);

    localparam int TICK_W = cnt_width(max_int(OVERSAMPLE, N_STOP_TICKS));
    localparam int BIT_W  = cnt_width(N_DATA_BITS);

    localparam logic [TICK_W-1:0] TICK_LAST_BIT  = TICK_W'(OVERSAMPLE - 1);
    localparam logic [TICK_W-1:0] TICK_LAST_STOP = TICK_W'(N_STOP_TICKS - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST       = BIT_W'(N_DATA_BITS - 1);

    uart_state_t            state, state_d;
    logic [N_DATA_BITS-1:0] shreg, shreg_d;
    logic [TICK_W-1:0]      tick_cnt, tick_cnt_d;
    logic [BIT_W-1:0]       bit_cnt, bit_cnt_d;
    logic                   tx_d;
    logic                   tick;
    logic                   accept;
    logic                   bit_end;
    logic                   stop_end;

    assign accept   = (state == IDLE) && is_tx_start;
    assign bit_end  = tick && (tick_cnt == TICK_LAST_BIT);
    assign stop_end = tick && (tick_cnt == TICK_LAST_STOP);

    // Divider restarts on accept so every frame is exactly the same length.
    baud_rate_gen #(
        .BAUD_DIV (BAUD_DIV)
    ) u_baud (
        .clk     (clk),
        .rst     (rst),
        .i_clear (accept),
        .o_tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            shreg    <= '0;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            o_tx     <= 1'b1;
        end else begin
            state    <= state_d;
            shreg    <= shreg_d;
            tick_cnt <= tick_cnt_d;
            bit_cnt  <= bit_cnt_d;
            o_tx     <= tx_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (is_tx_start)                       state_d = START;
            START:   if (bit_end)                           state_d = DATA;
            DATA:    if (bit_end && (bit_cnt == BIT_LAST))  state_d = STOP;
            STOP:    if (stop_end)                          state_d = IDLE;
            default:                                        state_d = IDLE;
        endcase
    end

    always_comb begin
        shreg_d    = shreg;
        tick_cnt_d = tick_cnt;
        bit_cnt_d  = bit_cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    shreg_d    = i_tx_data;
                    tick_cnt_d = '0;
                    bit_cnt_d  = '0;
                end
            end
            START: begin
                if (tick) tick_cnt_d = bit_end ? '0 : tick_cnt + 1'b1;
                if (bit_end) bit_cnt_d = '0;
            end
            DATA: begin
                if (tick) tick_cnt_d = bit_end ? '0 : tick_cnt + 1'b1;
                if (bit_end) begin
                    shreg_d   = shreg >> 1;
                    bit_cnt_d = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
                end
            end
            STOP: begin
                if (tick) tick_cnt_d = stop_end ? '0 : tick_cnt + 1'b1;
            end
            default: begin
                tick_cnt_d = '0;
                bit_cnt_d  = '0;
            end
        endcase
    end

    // Line level is derived from the next state so o_tx changes in the same cycle as state.
    always_comb begin
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shreg_d[0];
            default: tx_d = 1'b1;
        endcase
        os_tx_done = (state == STOP) && stop_end;
        o_tx_busy  = (state != IDLE);
    end

endmodule
